// File: rtl/kd_tree_sequencer.sv
// rtl/kd_tree_sequencer.sv - drives a k-d tree build: tree reset, center fill from memory, sort handshake
// Optional watchdog and ERR state: define KD_TREE_SEQ_TIMEOUT_EN.
module kd_tree_sequencer #(
    parameter int COMMAND_SIZE   = 5,
    parameter int DATA_SIZE      = 24,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_SIZE-1:0]    mem_rdata,
    output logic [COMMAND_SIZE-1:0] cmd_to_root,
    output logic [DATA_SIZE-1:0]    data_to_root,
    input  logic [COMMAND_SIZE-1:0] cmd_from_root,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [COMMAND_SIZE-1:0] CMD_NOP           = COMMAND_SIZE'(5'h00);
    localparam logic [COMMAND_SIZE-1:0] CMD_RST           = COMMAND_SIZE'(5'h1f);
    localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE      = COMMAND_SIZE'(5'h1e);
    localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL   = COMMAND_SIZE'(5'h01);
    localparam logic [COMMAND_SIZE-1:0] CMD_FILL_DONE     = COMMAND_SIZE'(5'h05);
    localparam logic [COMMAND_SIZE-1:0] CMD_START_SORTING = COMMAND_SIZE'(5'h09);
    localparam logic [COMMAND_SIZE-1:0] CMD_VALID_SORT    = COMMAND_SIZE'(5'h0f);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("kd_tree_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_TREE,
        S_FILL,
        S_SORT_START,
        S_SORT_WAIT,
        S_FINISH
`ifdef KD_TREE_SEQ_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t                    state_q, state_d;
    logic [COMMAND_SIZE-1:0]   cmd_q, cmd_d;
    logic [DATA_SIZE-1:0]      data_q, data_d;
    logic                      rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic                      rd_valid_q;
    logic                      sort_seen_q, sort_seen_d;

`ifdef KD_TREE_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_counting;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = CMD_NOP;
        data_d      = '0;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        sort_seen_d = (state_q == S_SORT_START) && (cmd_from_root == CMD_VALID_SORT);

        case (state_q)
            S_IDLE:       if (start) state_d = S_RST_TREE;
            S_RST_TREE:   if (cmd_from_root == CMD_RST_DONE) state_d = S_FILL;
            S_FILL:       if (cmd_from_root == CMD_FILL_DONE) state_d = S_SORT_START;
            S_SORT_START: state_d = S_SORT_WAIT;
            // valid_sort seen during SORT_START is remembered so SORT_WAIT still lasts one cycle
            S_SORT_WAIT:  if (cmd_from_root == CMD_VALID_SORT || sort_seen_q) state_d = S_FINISH;
            S_FINISH:     state_d = S_IDLE;
`ifdef KD_TREE_SEQ_TIMEOUT_EN
            S_ERR:        state_d = S_ERR;
`endif
            default:      state_d = S_IDLE;
        endcase

`ifdef KD_TREE_SEQ_TIMEOUT_EN
        wd_counting = (state_q == S_RST_TREE) || (state_q == S_FILL) || (state_q == S_SORT_WAIT);
        if (wd_counting && state_d == state_q && wd_q == WD_LAST) state_d = S_ERR;
        wd_d = (wd_counting && state_d == state_q) ? wd_q + 1'b1 : '0;
`endif

        // outputs are registered, so they are decoded from the state being entered
        case (state_d)
            S_RST_TREE: begin
                cmd_d  = CMD_RST;
                busy_d = 1'b1;
            end
            S_FILL: begin
                rd_en_d = 1'b1;
                busy_d  = 1'b1;
                addr_d  = (state_q == S_FILL) ? addr_q + 1'b1 : '0;
                if (state_q == S_FILL && rd_valid_q) begin
                    cmd_d  = CMD_CENTER_FILL;
                    data_d = mem_rdata;
                end
            end
            S_SORT_START: begin
                cmd_d  = CMD_START_SORTING;
                busy_d = 1'b1;
            end
            S_SORT_WAIT:  busy_d = 1'b1;
            S_FINISH: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
`ifdef KD_TREE_SEQ_TIMEOUT_EN
            S_ERR:        error_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= CMD_NOP;
            data_q      <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            sort_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            rd_valid_q  <= rd_en_q;
            sort_seen_q <= sort_seen_d;
        end
    end

`ifdef KD_TREE_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`endif

    assign mem_rd_en    = rd_en_q;
    assign mem_addr     = addr_q;
    assign cmd_to_root  = cmd_q;
    assign data_to_root = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_kd_tree_sequencer.sv
// tb/tb_kd_tree_sequencer.sv - scoreboard bench: full build on ADDR_W=5, wrap/same-cycle sort/watchdog on ADDR_W=3
`timescale 1ns/1ps
module tb_kd_tree_sequencer;

    localparam int CW = 5, DW = 24, AW_A = 5, AW_B = 3;
    localparam logic [4:0] NOP = 5'h00, RST = 5'h1f, RST_DONE = 5'h1e, CFILL = 5'h01,
                           CFILL_DONE = 5'h05, START_SORT = 5'h09, VALID_SORT = 5'h0f;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b;
    logic            rd_en_a, busy_a, done_a, error_a;
    logic [AW_A-1:0] addr_a;
    logic [DW-1:0]   rdata_a = '0, data_a;
    logic [CW-1:0]   cmd_a, from_a = NOP;
    logic            rd_en_b, busy_b, done_b, error_b;
    logic [AW_B-1:0] addr_b;
    logic [DW-1:0]   rdata_b = '0, data_b;
    logic [CW-1:0]   cmd_b, from_b = NOP;

    kd_tree_sequencer #(.ADDR_W(AW_A)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mem_rd_en(rd_en_a), .mem_addr(addr_a),
        .mem_rdata(rdata_a), .cmd_to_root(cmd_a), .data_to_root(data_a), .cmd_from_root(from_a),
        .busy(busy_a), .done(done_a), .error(error_a));

    kd_tree_sequencer #(.ADDR_W(AW_B), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mem_rd_en(rd_en_b), .mem_addr(addr_b),
        .mem_rdata(rdata_b), .cmd_to_root(cmd_b), .data_to_root(data_b), .cmd_from_root(from_b),
        .busy(busy_b), .done(done_b), .error(error_b));

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [8];
    always @(posedge clk) begin
        if (rd_en_a) rdata_a <= mem_a[addr_a];
        if (rd_en_b) rdata_b <= mem_b[addr_b];
    end

    // root node models: answer on the falling edge so the DUT samples on the next rising edge
    int rst_cnt_a = 0, fill_cnt_a = 0, sort_cnt_a = -1;
    always @(negedge clk) begin
        from_a = NOP;
        if (!reset) begin
            if (cmd_a == RST) begin rst_cnt_a++; fill_cnt_a = 0; end
            else rst_cnt_a = 0;
            if (rst_cnt_a == 3) from_a = RST_DONE;
            if (cmd_a == CFILL) begin
                fill_cnt_a++;
                if (fill_cnt_a == 20) from_a = CFILL_DONE;
            end
            if (cmd_a == START_SORT) sort_cnt_a = 0;
            else if (sort_cnt_a >= 0) sort_cnt_a++;
            if (sort_cnt_a == 10) begin from_a = VALID_SORT; sort_cnt_a = -1; end
        end else begin
            rst_cnt_a = 0; fill_cnt_a = 0; sort_cnt_a = -1;
        end
    end

    bit rst_ok_b = 1'b1;
    int rst_cnt_b = 0, fill_cnt_b = 0;
    always @(negedge clk) begin
        from_b = NOP;
        if (!reset) begin
            if (cmd_b == RST) begin rst_cnt_b++; fill_cnt_b = 0; end
            else rst_cnt_b = 0;
            if (rst_ok_b && rst_cnt_b == 2) from_b = RST_DONE;
            if (cmd_b == CFILL) begin
                fill_cnt_b++;
                if (fill_cnt_b == 10) from_b = CFILL_DONE;
            end
            if (cmd_b == START_SORT) from_b = VALID_SORT;
        end
    end

    logic [DW-1:0]   exp_a[$], exp_b[$];
    bit              sb_a = 1'b0, sb_b = 1'b0, rd_prev_b = 1'b0, wrap_b = 1'b0;
    int              fills_a = 0, fills_b = 0;
    logic [AW_B-1:0] addr_exp_b = '0, addr_prev_b = '0;
    always @(negedge clk) begin
        if (sb_a && cmd_a == CFILL) begin
            fills_a++;
            if (exp_a.size() > 0) check("fill_a_data", data_a, exp_a.pop_front());
        end
        if (sb_b && cmd_b == CFILL) begin
            fills_b++;
            if (exp_b.size() > 0) check("fill_b_data", data_b, exp_b.pop_front());
        end
        if (sb_b && rd_en_b) begin
            if (!rd_prev_b) addr_exp_b = '0;
            check("addr_b", addr_b, addr_exp_b);
            if (rd_prev_b && addr_prev_b == 3'd7 && addr_b == 3'd0) wrap_b = 1'b1;
            addr_exp_b = addr_exp_b + 1'b1;
        end
        rd_prev_b   = rd_en_b;
        addr_prev_b = addr_b;
    end

    task automatic check_reset_a(input string tag);
        check({tag, "_cmd"},   cmd_a,   NOP);
        check({tag, "_data"},  data_a,  0);
        check({tag, "_rd_en"}, rd_en_a, 0);
        check({tag, "_addr"},  addr_a,  0);
        check({tag, "_busy"},  busy_a,  0);
        check({tag, "_done"},  done_a,  0);
        check({tag, "_error"}, error_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        int n;
        reset = 1'b1; start_a = 1'b1; start_b = 1'b1;
        for (int i = 0; i < 32; i++) mem_a[i] = (i < 20) ? DW'(i + 1) : DW'(32'hEE0000 + i);
        for (int i = 0; i < 8; i++)  mem_b[i] = DW'(32'h000100 + i);
        repeat (3) @(negedge clk);
        check_reset_a("reset");
        check("reset_b_busy", busy_b, 0);
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        check("idle_busy", busy_a, 0);

        // abort a build in FILL at mem_addr 7
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        n = 0;
        while (!(rd_en_a && addr_a == 7) && n < 100) begin @(negedge clk); n++; end
        check("abort_reach", n < 100, 1);
        reset = 1'b1; @(negedge clk);
        check_reset_a("abort");
        reset = 1'b0;

        // fresh full build
        for (int i = 1; i <= 20; i++) exp_a.push_back(DW'(i));
        sb_a = 1'b1;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        n = 0;
        while (cmd_a == RST && n < 50) begin check("rst_busy", busy_a, 1); @(negedge clk); n++; end
        check("rst_cycles", n, 3);
        check("fill1_rd_en", rd_en_a, 1);
        check("fill1_addr", addr_a, 0);
        check("fill1_cmd", cmd_a, NOP);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        check("fill2_addr", addr_a, 1);
        check("fill2_cmd", cmd_a, NOP);
        @(negedge clk);
        check("fill_latency", cmd_a, CFILL);
        n = 0;
        while (cmd_a != START_SORT && n < 100) begin @(negedge clk); n++; end
        check("sort_start_cmd", cmd_a, START_SORT);
        check("sort_start_rd_en", rd_en_a, 0);
        check("sort_start_data", data_a, 0);
        n = 0;
        do begin
            start_a = (n == 3);
            @(negedge clk); n++;
            if (n == 1) check("sort_once", cmd_a, NOP);
        end while (!done_a && n < 50);
        start_a = 1'b0;
        check("done_latency", n, 11);
        check("done_busy", busy_a, 1);
        @(negedge clk);
        check("done_pulse", done_a, 0);
        check("post_busy", busy_a, 0);
        check("post_cmd", cmd_a, NOP);
        check("fill_a_count", fills_a, 20);
        check("fill_a_left", exp_a.size(), 0);
        repeat (5) @(negedge clk);
        check("start_ignored", busy_a, 0);
        sb_a = 1'b0;

        // ADDR_W=3: address wrap and valid_sort coinciding with start_sorting
        for (int i = 0; i < 10; i++) exp_b.push_back(DW'(32'h000100 + (i % 8)));
        sb_b = 1'b1;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        n = 0;
        while (cmd_b != START_SORT && n < 100) begin @(negedge clk); n++; end
        check("b_sort_cmd", cmd_b, START_SORT);
        @(negedge clk);
        check("b_wait_cmd", cmd_b, NOP);
        check("b_wait_done", done_b, 0);
        check("b_wait_busy", busy_b, 1);
        @(negedge clk);
        check("b_done", done_b, 1);
        @(negedge clk);
        check("b_post_busy", busy_b, 0);
        check("fill_b_count", fills_b, 10);
        check("addr_b_wrap", wrap_b, 1);
        sb_b = 1'b0;

        // root never answers rst
        rst_ok_b = 1'b0;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        n = 0;
        while (cmd_b == RST && n < 100) begin @(negedge clk); n++; end
`ifdef KD_TREE_SEQ_TIMEOUT_EN
        check("to_rst_cycles", n, 16);
        check("to_error", error_b, 1);
        check("to_busy", busy_b, 0);
        check("to_rd_en", rd_en_b, 0);
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        repeat (3) @(negedge clk);
        check("to_sticky", error_b, 1);
        check("to_start_ignored", cmd_b, NOP);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        check("to_cleared", error_b, 0);
`else
        check("nowd_rst_cycles", n, 100);
        check("nowd_error", error_b, 0);
        check("nowd_busy", busy_b, 1);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        check("nowd_reset_busy", busy_b, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
